// File: rtl/ga_pkg.sv
// Shared definitions for the walking-ones operand sequencer: state encodings,
// vec_count width and the all-ones mask helper.
package ga_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Counter width able to hold the full sequence length WIDTH*(WIDTH-1).
  function automatic int cnt_width(input int width);
    return $clog2(width * (width - 1) + 1);
  endfunction

  function automatic logic [63:0] ones_mask(input int width);
    return (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
  endfunction

endpackage

// File: rtl/ga_gap_timer.sv
// Loadable down-counter that times the idle gap after each accepted vector.
// Loaded with GAP-1 on accept so that expire is seen on the last idle cycle.
module ga_gap_timer #(
  parameter  int GAP = 1,
  localparam int TW  = (GAP > 1) ? $clog2(GAP) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic expire
);

  logic [TW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= TW'(GAP - 1);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - TW'(1);
    end
  end

  assign expire = (r_cnt == '0);

endmodule

// File: rtl/ga_vec_seq.sv
// Walking-ones operand sequencer: a fills from the LSB, b drains from the MSB,
// each pair offered on valid/ready with an optional idle gap after every accept.
module ga_vec_seq
  import ga_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int GAP   = 1,
  localparam int CW    = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             valid,
  input  logic             ready,
  output logic             last,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    vec_count
);

  localparam logic [WIDTH-1:0] ALL_ONES = WIDTH'(ones_mask(WIDTH));
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH-1:0] w_a_grow;
  logic             w_b_is_one;
  logic             w_valid;
  logic             w_last;
  logic             w_accept;
  logic             w_start;
  logic             w_gap_expire;

  assign w_a_grow   = (r_a << 1) | ONE;
  assign w_b_is_one = (r_b == ONE);
  assign w_valid    = (r_state == S_DRIVE);
  // a never reaches all ones: the pair before that wrap is the final vector.
  assign w_last     = w_valid && w_b_is_one && (w_a_grow == ALL_ONES);
  assign w_accept   = w_valid && ready;
  assign w_start    = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  generate
    if (GAP > 0) begin : g_gap
      ga_gap_timer #(.GAP(GAP)) u_gap_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (w_accept && !w_last),
        .expire (w_gap_expire)
      );
    end else begin : g_no_gap
      assign w_gap_expire = 1'b1;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) w_next = S_DRIVE;
      end
      S_DRIVE: begin
        if (w_accept) begin
          if (w_last)       w_next = S_DONE;
          else if (GAP > 0) w_next = S_GAP;
          else              w_next = S_DRIVE;
        end
      end
      S_GAP: begin
        if (w_gap_expire) w_next = S_DRIVE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= ONE;
      r_b   <= ALL_ONES;
      r_cnt <= '0;
    end else if (w_start) begin
      r_a   <= ONE;
      r_b   <= ALL_ONES;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= r_cnt + CW'(1);
      if (!w_last) begin
        if (w_b_is_one) begin
          r_a <= w_a_grow;
          r_b <= ALL_ONES;
        end else begin
          r_b <= r_b >> 1;
        end
      end
    end
  end

  assign a         = r_a;
  assign b         = r_b;
  assign valid     = w_valid;
  assign last      = w_last;
  assign busy      = (r_state == S_DRIVE) || (r_state == S_GAP);
  assign done      = (r_state == S_DONE);
  assign vec_count = r_cnt;

endmodule

// File: tb/tb_ga_vec_seq.sv
// Scoreboard bench: two sequencers (GAP=0 and GAP=2) share start; expected
// vectors are queued by the stimulus and popped by a negedge monitor.
module tb_ga_vec_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        ready0 = 1'b0, ready2 = 1'b0;
  logic [15:0] a0, b0, a2, b2;
  logic        v0, l0, bs0, dn0, v2, l2, bs2, dn2;
  logic [7:0]  c0, c2;

  int n_chk = 0;
  int n_err = 0;
  int rdy_mode = 0;
  int st0 = 0, st2 = 0;
  int gc [2];
  int dc [2];
  logic        pst [2];
  logic [32:0] pv  [2];
  logic [32:0] q0 [$];
  logic [32:0] q1 [$];

  always #5 clk = ~clk;

  ga_vec_seq #(.WIDTH(16), .GAP(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a0), .b(b0), .valid(v0),
    .ready(ready0), .last(l0), .busy(bs0), .done(dn0), .vec_count(c0));

  ga_vec_seq #(.WIDTH(16), .GAP(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a2), .b(b2), .valid(v2),
    .ready(ready2), .last(l2), .busy(bs2), .done(dn2), .vec_count(c2));

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[dut%0d] got=%h want=%h at %0t", nm, k, act, exp, $time);
    end
  endtask

  task automatic mon(input int k, input int gap, input logic [15:0] a, input logic [15:0] b,
                     input logic v, input logic r, input logic l, input logic bs,
                     input logic dn, input logic [7:0] cnt);
    logic [32:0] cur;
    logic [32:0] e;
    cur = {l, a, b};
    if (!rst_n) begin
      gc[k] = 0; dc[k] = 0; pst[k] = 1'b0;
      return;
    end
    if (pst[k]) chk("hold_under_stall", k, {31'd0, v, cur}, {31'd0, 1'b1, pv[k]});
    if (!v) chk("last_without_valid", k, {63'd0, l}, 64'd0);
    if (gc[k] > 0) begin
      chk("gap_valid", k, {63'd0, v}, {63'd0, gc[k] == 1});
      gc[k]--;
    end
    if (dc[k] != 0) begin
      chk("done_flags", k, {53'd0, dn, bs, v, cnt}, {53'd0, 1'b1, 1'b0, 1'b0, 8'd240});
      dc[k] = 0;
    end
    if (v && r) begin
      if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
        n_chk++; n_err++;
        $display("FAIL unexpected_vector[dut%0d] got=%h want=none", k, cur);
      end else begin
        e = (k == 0) ? q0.pop_front() : q1.pop_front();
        chk("vector", k, {31'd0, cur}, {31'd0, e});
      end
      if (l) dc[k] = 1;
      else   gc[k] = gap + 1;
    end
    pst[k] = v && !r;
    pv[k]  = cur;
  endtask

  always @(negedge clk) begin
    mon(0, 0, a0, b0, v0, ready0, l0, bs0, dn0, c0);
    mon(1, 2, a2, b2, v2, ready2, l2, bs2, dn2, c2);
  end

  // Ready driver: always high, or high with random 0-5 cycle stalls.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 0) begin
        ready0 = 1'b1; ready2 = 1'b1;
      end else begin
        if (st0 > 0) begin ready0 = 1'b0; st0--; end
        else begin ready0 = 1'b1; st0 = $urandom_range(0, 5); end
        if (st2 > 0) begin ready2 = 1'b0; st2--; end
        else begin ready2 = 1'b1; st2 = $urandom_range(0, 5); end
      end
    end
  end

  task automatic push_seq();
    logic [15:0] ea, eb;
    for (int i = 0; i < 15; i++) begin
      for (int j = 0; j < 16; j++) begin
        ea = 16'((32'd1 << (i + 1)) - 32'd1);
        eb = 16'hFFFF >> j;
        q0.push_back({(i == 14 && j == 15), ea, eb});
        q1.push_back({(i == 14 && j == 15), ea, eb});
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic chk_reset(input string nm);
    chk(nm, 0, {28'd0, v0, l0, bs0, dn0, c0, a0, b0}, {28'd0, 4'b0, 8'd0, 16'h0001, 16'hFFFF});
    chk(nm, 1, {28'd0, v2, l2, bs2, dn2, c2, a2, b2}, {28'd0, 4'b0, 8'd0, 16'h0001, 16'hFFFF});
  endtask

  task automatic wait_done(input string nm);
    for (int i = 0; i < 4000 && !(dn0 && dn2); i++) @(negedge clk);
    @(negedge clk);
    chk({nm, "_done"}, 0, {62'd0, dn0, dn2}, 64'd3);
    chk({nm, "_count"}, 0, {48'd0, c0, c2}, {48'd0, 8'd240, 8'd240});
    chk({nm, "_queue_drained"}, 0, 64'(q0.size() + q1.size()), 64'd0);
  endtask

  initial begin
    logic [7:0] vc0, vc2;
    gc[0] = 0; gc[1] = 0; dc[0] = 0; dc[1] = 0; pst[0] = 1'b0; pst[1] = 1'b0;
    #12;
    chk_reset("reset_values");
    @(negedge clk); #2 rst_n = 1'b1;

    // Full sequence, ready held high.
    rdy_mode = 0;
    @(negedge clk);
    push_seq();
    @(negedge clk); #2;
    pulse_start();
    chk("first_cycle", 0, {44'd0, v0, bs0, dn0, c0, 1'b0, a0[1:0], b0[15:14]},
        {44'd0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 2'b01, 2'b11});
    chk("first_cycle", 1, {28'd0, v2, bs2, dn2, 1'b0, c2, a2, b2},
        {28'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 16'h0001, 16'hFFFF});
    wait_done("seq_ready_high");

    // Restart from DONE with random stalls; start pulsed mid-sequence is ignored.
    rdy_mode = 1;
    push_seq();
    @(negedge clk); #2;
    pulse_start();
    chk("done_clears", 0, {62'd0, dn0, dn2}, 64'd0);
    for (int i = 0; i < 2000 && c0 < 8'd50; i++) @(negedge clk);
    for (int i = 0; i < 200 && !(bs2 && !v2); i++) @(negedge clk);
    chk("reached_gap", 1, {62'd0, bs2, v2}, 64'd2);
    vc0 = c0; vc2 = c2;
    pulse_start();
    chk("start_ignored", 0, {63'd0, (c0 >= vc0) && bs0}, 64'd1);
    chk("start_ignored", 1, {63'd0, (c2 >= vc2) && bs2}, 64'd1);
    wait_done("seq_stalled");

    // Reset in the middle of a sequence, then a fresh full run.
    push_seq();
    @(negedge clk); #2;
    pulse_start();
    for (int i = 0; i < 2000 && c0 < 8'd100; i++) @(negedge clk);
    chk("reached_vec100", 0, {56'd0, c0}, 64'd100);
    #2 rst_n = 1'b0;
    #1;
    chk_reset("mid_reset");
    q0.delete(); q1.delete();
    @(negedge clk); @(negedge clk); #2 rst_n = 1'b1;
    push_seq();
    @(negedge clk); #2;
    pulse_start();
    chk("restart_first", 0, {32'd0, a0, b0}, {32'd0, 16'h0001, 16'hFFFF});
    wait_done("seq_after_reset");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
